// File: rtl/msrv32_fetch_ctrl_pkg.sv
// rtl/msrv32_fetch_ctrl_pkg.sv - shared types and constants for the fetch/flush controller
package msrv32_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0 -- the bubble word fed to the instruction mux
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/msrv32_sat_counter.sv
// rtl/msrv32_sat_counter.sv - saturating up-counter with synchronous clear
module msrv32_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/msrv32_fetch_flush_ctrl.sv
// rtl/msrv32_fetch_flush_ctrl.sv - fetch sequencing, stall hold and redirect flush (perf counters under FETCH_CTRL_PERF_EN)
module msrv32_fetch_flush_ctrl
    import msrv32_fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic [31:0]      ms_riscv32_mp_instr_in,
    input  logic             ms_riscv32_mp_instr_hready_in,
    input  logic             ms_riscv32_mp_data_hready_in,
    input  logic             branch_taken_in,
    input  logic             trap_taken_in,
    output logic             instr_req_out,
    output logic             pc_en_out,
    output logic             flush_out,
    output logic [31:0]      instr_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] flush_count_out,
    output logic [CNT_W-1:0] stall_count_out
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic         clk;
    logic         rst;
    logic         ihr;
    logic         dhr;
    logic         redirect;
    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  hold_q;
    logic [31:0]  hold_d;
    logic [2:0]   bub_q;
    logic [2:0]   bub_d;

    assign clk       = ms_riscv32_mp_clk_in;
    assign rst       = ms_riscv32_mp_rst_in;
    assign ihr       = ms_riscv32_mp_instr_hready_in;
    assign dhr       = ms_riscv32_mp_data_hready_in;
    assign redirect  = branch_taken_in | trap_taken_in;
    assign state_out = state_q;

    // State, stall hold word and remaining-bubble count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            hold_q  <= NOP_INSTR;
            bub_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            bub_q   <= bub_d;
        end
    end

    // Next state and fetch-side outputs; a dmem wait outranks everything
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        bub_d         = bub_q;
        flush_out     = 1'b1;
        pc_en_out     = 1'b0;
        instr_req_out = 1'b1;
        instr_out     = NOP_INSTR;
        case (state_q)
            S_RESET: begin
                // state is forced here while rst is high, so no request then
                instr_req_out = ~rst;
                state_d       = S_FETCH;
            end
            S_FETCH: begin
                instr_out = ms_riscv32_mp_instr_in;
                flush_out = 1'b0;
                if (!dhr) begin
                    state_d = S_STALL;
                    hold_d  = ihr ? ms_riscv32_mp_instr_in : NOP_INSTR;
                end else if (redirect) begin
                    state_d   = S_FLUSH;
                    bub_d     = FLUSH_LOAD;
                    pc_en_out = 1'b1;
                end else if (!ihr) begin
                    flush_out = 1'b1;
                end else begin
                    pc_en_out = 1'b1;
                end
            end
            S_STALL: begin
                instr_out = hold_q;
                flush_out = 1'b0;
                pc_en_out = dhr;
                if (dhr) begin
                    state_d = S_FETCH;
                end
            end
            S_FLUSH: begin
                pc_en_out = ihr & dhr;
                if (dhr) begin
                    if (redirect) begin
                        bub_d = FLUSH_LOAD;
                    end else if (ihr) begin
                        bub_d = bub_q - 3'd1;
                        if (bub_q == 3'd1) begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

`ifdef FETCH_CTRL_PERF_EN
    msrv32_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_out),
        .clr   (1'b0),
        .count (flush_count_out)
    );

    msrv32_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == S_STALL),
        .clr   (1'b0),
        .count (stall_count_out)
    );
`else
    assign flush_count_out = '0;
    assign stall_count_out = '0;
`endif

endmodule
